inst_scheduler: RTL
===================

# inst_scheduler

Sequences network execution by fetching 80-bit layer instructions from instruction memory and issuing them one at a time to the PE-array layer engine. It sits between the SPI command/memory interface and the layer engine inside `top_design`. It raises `done_int` when the program completes and holds off host SPI memory access while a program is running.

## Interface
- `WIDTH_ADDR_INST`, 6: instruction memory address width
- `WIDTH_INST_MEM`, 80: instruction word width; bit `WIDTH_INST_MEM-1` is the LAST flag
- `DEPTH_INST_MEM`, 64: instruction memory depth
- `clk` in 1: system clock (PLL output)
- `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle run request from the SPI command decoder
- `abort` in 1: one-cycle stop request
- `num_inst` in `WIDTH_ADDR_INST+1`: number of instructions to run, 1..`DEPTH_INST_MEM`
- `inst_rd_en` out 1: instruction memory read strobe
- `inst_rd_addr` out `WIDTH_ADDR_INST`: instruction read address
- `inst_rd_data` in `WIDTH_INST_MEM`: read data, valid one cycle after `inst_rd_en`
- `layer_cfg` out `WIDTH_INST_MEM`: registered instruction for the layer engine
- `layer_start` out 1: one-cycle pulse that launches the engine with `layer_cfg`
- `layer_done` in 1: one-cycle pulse when the engine finishes the current layer
- `busy` out 1: program running; the SPI block must reject memory writes while high
- `done_int` out 1: completion interrupt, level
- `err` out 1: sticky error, set on an illegal `num_inst`

## Operation
- States: IDLE, FETCH, WAIT_RD, ISSUE, RUN, DONE.
- IDLE
  - On `start` with `num_inst` in 1..`DEPTH_INST_MEM`: clear `done_int` and `err`, set PC=0 and count=0, go to FETCH.
  - On `start` with `num_inst`=0 or >`DEPTH_INST_MEM`: set `err`, stay in IDLE, leave `done_int` unchanged.
- FETCH: assert `inst_rd_en` with `inst_rd_addr`=PC for one cycle, then go to WAIT_RD.
- WAIT_RD: capture `inst_rd_data` into `layer_cfg`, then go to ISSUE.
- ISSUE: pulse `layer_start` for one cycle, increment count, go to RUN.
- RUN: on `layer_done`:
  - If the LAST flag of `layer_cfg` is set, or count==`num_inst`, go to DONE.
  - Otherwise PC←PC+1 and go to FETCH.
  - PC saturates at `DEPTH_INST_MEM-1`; reaching the end of memory without the LAST flag ends the program, with no wrap to 0.
- DONE: set `done_int`, go to IDLE. `done_int` holds until the next accepted `start` or until reset.
- `abort` in any non-IDLE state: go to IDLE next cycle without setting `done_int`. An in-flight engine layer is not cancelled; any later `layer_done` is ignored in IDLE.
- `start` outside IDLE is ignored.
- `layer_done` outside RUN is ignored.
- `abort` and `layer_done` in the same RUN cycle: `abort` wins.
- `busy` = (state != IDLE) && (state != DONE).
- Reset values:
  - state IDLE; PC 0; count 0
  - `layer_cfg` 0; `layer_start` 0; `inst_rd_en` 0; `inst_rd_addr` 0
  - `busy` 0; `done_int` 0; `err` 0
- Reset mid-program: return to IDLE immediately (asynchronous); no `done_int`.

## Timing
- All outputs are registered.
- `start` accepted at edge N:
  - `inst_rd_en` high in cycle N+1
  - `layer_cfg` valid at N+3
  - `layer_start` high in cycle N+3
- `layer_done` at edge M (non-final layer): `inst_rd_en` at M+1, next `layer_start` at M+3. Per-layer overhead is 3 cycles.
- Final `layer_done` at edge M: state DONE at M+1, `done_int` high from M+2, `busy` low from M+1.
- `layer_cfg` is stable from ISSUE until the next WAIT_RD capture.

## Structure
- Shared package holds:
  - state encoding enum
  - LAST-flag bit index constant
  - default widths (6/80/64)
  - the `num_inst` legality function
- Single flat module; no sub-module. The instruction memory stays external so the SPI loader can share it via `busy`.

## Test plan
- Load 3 instructions with LAST clear, `num_inst`=3, `start` → exactly 3 `layer_start` pulses, `inst_rd_addr` 0,1,2, `layer_cfg` matches each word, `done_int` rises 2 cycles after the third `layer_done`.
- `num_inst`=10 with LAST set on word 4 → 5 layers issued, then `done_int`; `busy` low afterward.
- `num_inst`=0, then `num_inst`=65, each with `start` → `err`=1, no `inst_rd_en`, `busy` stays 0.
- `abort` in RUN during layer 2 → IDLE next cycle, `done_int`=0, a subsequent `layer_done` is ignored, and a new `start` runs from address 0.
- Assert `reset_n` low mid-RUN → all outputs return to reset values immediately. Also: `start` while `busy` is ignored, and `abort` coincident with `layer_done` produces no `done_int`.
- `num_inst`=64, LAST clear on all words → addresses 0..63 issued, PC stops at 63 with no wrap, `done_int` after the 64th `layer_done`.

Source files
------------

// File: rtl/inst_scheduler_pkg.sv
// Shared definitions for the layer instruction scheduler: default geometry,
// FSM state encoding, LAST-flag position and the program-length legality rule.
package inst_scheduler_pkg;

  localparam int DEF_WIDTH_ADDR_INST = 6;
  localparam int DEF_WIDTH_INST_MEM  = 80;
  localparam int DEF_DEPTH_INST_MEM  = 64;

  // LAST flag is the MSB of an instruction word
  localparam int LAST_FLAG_IDX = DEF_WIDTH_INST_MEM - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_RD,
    ST_ISSUE,
    ST_RUN,
    ST_DONE
  } state_e;

  function automatic logic num_inst_legal(input int unsigned n, input int unsigned depth);
    return (n != 0) && (n <= depth);
  endfunction

endpackage

// File: rtl/inst_scheduler_if.sv
// Instruction-memory read port and layer-engine launch/complete handshake.
interface inst_scheduler_if
  import inst_scheduler_pkg::*;
#(
  parameter int WIDTH_ADDR_INST = DEF_WIDTH_ADDR_INST,
  parameter int WIDTH_INST_MEM  = DEF_WIDTH_INST_MEM
);

  logic                       inst_rd_en;
  logic [WIDTH_ADDR_INST-1:0] inst_rd_addr;
  logic [WIDTH_INST_MEM-1:0]  inst_rd_data;
  logic [WIDTH_INST_MEM-1:0]  layer_cfg;
  logic                       layer_start;
  logic                       layer_done;

  modport master (
    output inst_rd_en, inst_rd_addr, layer_cfg, layer_start,
    input  inst_rd_data, layer_done
  );

  modport slave (
    input  inst_rd_en, inst_rd_addr, layer_cfg, layer_start,
    output inst_rd_data, layer_done
  );

endinterface

// File: rtl/inst_scheduler.sv
// Fetches layer instructions one at a time and launches the PE-array engine on
// each; raises done_int at program end and holds busy while a program runs.
module inst_scheduler
  import inst_scheduler_pkg::*;
#(
  parameter int WIDTH_ADDR_INST = DEF_WIDTH_ADDR_INST,
  parameter int WIDTH_INST_MEM  = DEF_WIDTH_INST_MEM,
  parameter int DEPTH_INST_MEM  = DEF_DEPTH_INST_MEM
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [WIDTH_ADDR_INST:0] num_inst,
  inst_scheduler_if.master         bus,
  output logic                     busy,
  output logic                     done_int,
  output logic                     err
);

  localparam logic [WIDTH_ADDR_INST-1:0] PC_MAX = WIDTH_ADDR_INST'(DEPTH_INST_MEM - 1);

  state_e                     state_q,  state_d;
  logic [WIDTH_ADDR_INST-1:0] pc_q,     pc_d;
  logic [WIDTH_ADDR_INST:0]   cnt_q,    cnt_d;
  logic [WIDTH_ADDR_INST:0]   num_q,    num_d;
  logic [WIDTH_INST_MEM-1:0]  cfg_q,    cfg_d;
  logic                       rd_en_q,  rd_en_d;
  logic [WIDTH_ADDR_INST-1:0] rd_addr_q, rd_addr_d;
  logic                       lstart_q, lstart_d;
  logic                       busy_q,   busy_d;
  logic                       done_q,   done_d;
  logic                       err_q,    err_d;

  logic start_ok;
  assign start_ok = num_inst_legal(32'(num_inst), DEPTH_INST_MEM);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    cfg_d     = cfg_q;
    rd_addr_d = rd_addr_q;
    done_d    = done_q;
    err_d     = err_q;

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (start_ok) begin
              done_d  = 1'b0;
              err_d   = 1'b0;
              pc_d    = '0;
              cnt_d   = '0;
              num_d   = num_inst;
              state_d = ST_FETCH;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_FETCH:   state_d = ST_WAIT_RD;
        ST_WAIT_RD: begin
          cfg_d   = bus.inst_rd_data;
          state_d = ST_ISSUE;
        end
        ST_ISSUE: begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (bus.layer_done) begin
            // End of memory terminates the program; the PC never wraps.
            if (cfg_q[LAST_FLAG_IDX] || (cnt_q == num_q) || (pc_q == PC_MAX)) begin
              state_d = ST_DONE;
            end else begin
              pc_d    = pc_q + 1'b1;
              state_d = ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Strobes are registered from the next state so they line up with it.
    rd_en_d  = (state_d == ST_FETCH);
    lstart_d = (state_d == ST_ISSUE);
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
    if (rd_en_d) begin
      rd_addr_d = pc_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      num_q     <= '0;
      cfg_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      lstart_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      num_q     <= num_d;
      cfg_q     <= cfg_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      lstart_q  <= lstart_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.inst_rd_en   = rd_en_q;
  assign bus.inst_rd_addr = rd_addr_q;
  assign bus.layer_cfg    = cfg_q;
  assign bus.layer_start  = lstart_q;
  assign busy             = busy_q;
  assign done_int         = done_q;
  assign err              = err_q;

endmodule
